// File: rtl/note_track_ctrl_pkg.sv
// Shared types for the falling-note playfield sequencer: FSM states,
// field widths and the per-slot record.
package note_track_ctrl_pkg;

  localparam int LANE_W = 3;
  localparam int Y_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_JUDGE   = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  typedef struct packed {
    logic              active;
    logic [LANE_W-1:0] lane;
    logic [Y_W-1:0]    y;
  } slot_t;

endpackage

// File: rtl/note_track_ctrl_slot_alloc.sv
// Priority encoder over the slot pool: lowest-index inactive slot plus a
// flag saying whether any slot is free at all.
module note_slot_alloc #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] active_vec,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 free_any
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_vec[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_track_ctrl.sv
// Falling-note playfield sequencer. Owns the slot pool, advances notes on
// each frame tick (retiring those that fall off screen as misses), accepts
// spawns and judges strums against the hit window.
//
// Handshakes: spawn and strum each use valid/ready; a transfer happens on a
// rising clock edge where both valid and ready are high. ready never depends
// on the matching valid, and valid may be raised or dropped at any time.
module note_track_ctrl
  import note_track_ctrl_pkg::*;
#(
  parameter int  NUM_SLOTS = 8,
  parameter int  NUM_LANES = 5,
  parameter int  SPEED     = 2,
  parameter int  SCREEN_H  = 480,
  parameter int  HIT_Y_MIN = 400,
  parameter int  HIT_Y_MAX = 440,
  localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              spawn_valid,
  input  logic [LANE_W-1:0] spawn_lane,
  output logic              spawn_ready,
  input  logic              strum_valid,
  input  logic [LANE_W-1:0] strum_lane,
  output logic              strum_ready,
  output logic              hit_pulse,
  output logic              bad_strum_pulse,
  output logic              miss_pulse,
  input  logic [IDX_W-1:0]  rd_slot,
  output logic              rd_active,
  output logic [LANE_W-1:0] rd_lane,
  output logic [Y_W-1:0]    rd_y,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int                LAST_SLOT   = NUM_SLOTS - 1;
  localparam logic [IDX_W-1:0]  LAST_IDX    = LAST_SLOT[IDX_W-1:0];
  localparam logic [LANE_W:0]   NUM_LANES_C = NUM_LANES[LANE_W:0];
  localparam logic [Y_W:0]      SPEED_C     = SPEED[Y_W:0];
  localparam logic [Y_W:0]      SCREEN_H_C  = SCREEN_H[Y_W:0];
  localparam logic [Y_W-1:0]    HIT_MIN_C   = HIT_Y_MIN[Y_W-1:0];
  localparam logic [Y_W-1:0]    HIT_MAX_C   = HIT_Y_MAX[Y_W-1:0];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [LANE_W-1:0]  strum_lane_q, strum_lane_d;
  logic               cand_found_q, cand_found_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [Y_W-1:0]     cand_y_q, cand_y_d;
  logic               hit_q, hit_d;
  logic               bad_q, bad_d;
  logic               miss_q, miss_d;
  slot_t              slots_q [NUM_SLOTS];
  slot_t              slots_d [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] active_vec;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_any;
  slot_t                cur;
  logic [Y_W:0]         y_next;
  logic                 lane_ok;
  logic                 cand_hit;

  // Gather the active bits for the free-slot encoder.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_vec[i] = slots_q[i].active;
    end
  end

  note_slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_alloc (
    .active_vec (active_vec),
    .free_idx   (free_idx),
    .free_any   (free_any)
  );

  assign spawn_ready     = (state_q == ST_IDLE) & free_any;
  assign strum_ready     = (state_q == ST_IDLE) & ~frame_tick;
  assign busy            = (state_q != ST_IDLE);
  assign dbg_state       = state_q;
  assign hit_pulse       = hit_q;
  assign bad_strum_pulse = bad_q;
  assign miss_pulse      = miss_q;
  assign rd_active       = slots_q[rd_slot].active;
  assign rd_lane         = slots_q[rd_slot].lane;
  assign rd_y            = slots_q[rd_slot].y;

  // Next-state, slot updates and pulse requests for the scan FSM.
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    strum_lane_d = strum_lane_q;
    cand_found_d = cand_found_q;
    cand_idx_d   = cand_idx_q;
    cand_y_d     = cand_y_q;
    hit_d        = 1'b0;
    bad_d        = 1'b0;
    miss_d       = 1'b0;
    slots_d      = slots_q;

    cur      = slots_q[scan_q];
    y_next   = {1'b0, cur.y} + SPEED_C;
    lane_ok  = ({1'b0, spawn_lane} < NUM_LANES_C);
    cand_hit = cur.active && (cur.lane == strum_lane_q) &&
               (cur.y >= HIT_MIN_C) && (cur.y <= HIT_MAX_C);

    case (state_q)
      ST_IDLE: begin
        // Out-of-range lanes are consumed without touching the pool.
        if (spawn_valid && spawn_ready && lane_ok) begin
          slots_d[free_idx].active = 1'b1;
          slots_d[free_idx].lane   = spawn_lane;
          slots_d[free_idx].y      = '0;
        end
        if (frame_tick) begin
          state_d = ST_ADVANCE;
          scan_d  = '0;
        end else if (strum_valid && strum_ready) begin
          state_d      = ST_JUDGE;
          scan_d       = '0;
          strum_lane_d = strum_lane;
          cand_found_d = 1'b0;
          cand_idx_d   = '0;
          cand_y_d     = '0;
        end
      end
      ST_ADVANCE: begin
        if (cur.active) begin
          if (y_next >= SCREEN_H_C) begin
            slots_d[scan_q].active = 1'b0;
            miss_d                 = 1'b1;
          end else begin
            slots_d[scan_q].y = y_next[Y_W-1:0];
          end
        end
        scan_d = scan_q + IDX_W'(1);
        if (scan_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_JUDGE: begin
        // Strictly greater keeps the lower index on a tie in y.
        if (cand_hit && (!cand_found_q || (cur.y > cand_y_q))) begin
          cand_found_d = 1'b1;
          cand_idx_d   = scan_q;
          cand_y_d     = cur.y;
        end
        scan_d = scan_q + IDX_W'(1);
        if (scan_q == LAST_IDX) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (cand_found_q) begin
          slots_d[cand_idx_q] = '0;
          hit_d               = 1'b1;
        end else begin
          bad_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, slot pool and pulse registers; reset empties the pool and
  // discards any judgment in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      scan_q       <= '0;
      strum_lane_q <= '0;
      cand_found_q <= 1'b0;
      cand_idx_q   <= '0;
      cand_y_q     <= '0;
      hit_q        <= 1'b0;
      bad_q        <= 1'b0;
      miss_q       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      strum_lane_q <= strum_lane_d;
      cand_found_q <= cand_found_d;
      cand_idx_q   <= cand_idx_d;
      cand_y_q     <= cand_y_d;
      hit_q        <= hit_d;
      bad_q        <= bad_d;
      miss_q       <= miss_d;
      slots_q      <= slots_d;
    end
  end

endmodule

// File: tb/tb_note_track_ctrl.sv
// Bench for note_track_ctrl: a slot-pool model plus an expected-pulse queue.
module tb_note_track_ctrl;
  import note_track_ctrl_pkg::*;

  localparam int NS   = 8;
  localparam int NL   = 5;
  localparam int SPD  = 2;
  localparam int SH   = 480;
  localparam int HMIN = 400;
  localparam int HMAX = 440;

  localparam logic [2:0] P_HIT  = 3'b100;
  localparam logic [2:0] P_BAD  = 3'b010;
  localparam logic [2:0] P_MISS = 3'b001;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       spawn_valid;
  logic [2:0] spawn_lane;
  logic       spawn_ready;
  logic       strum_valid;
  logic [2:0] strum_lane;
  logic       strum_ready;
  logic       hit_pulse;
  logic       bad_strum_pulse;
  logic       miss_pulse;
  logic [2:0] rd_slot;
  logic       rd_active;
  logic [2:0] rd_lane;
  logic [9:0] rd_y;
  logic       busy;
  state_e     dbg_state;

  always #10 clock = ~clock;

  note_track_ctrl #(
    .NUM_SLOTS (NS),
    .NUM_LANES (NL),
    .SPEED     (SPD),
    .SCREEN_H  (SH),
    .HIT_Y_MIN (HMIN),
    .HIT_Y_MAX (HMAX)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .spawn_valid     (spawn_valid),
    .spawn_lane      (spawn_lane),
    .spawn_ready     (spawn_ready),
    .strum_valid     (strum_valid),
    .strum_lane      (strum_lane),
    .strum_ready     (strum_ready),
    .hit_pulse       (hit_pulse),
    .bad_strum_pulse (bad_strum_pulse),
    .miss_pulse      (miss_pulse),
    .rd_slot         (rd_slot),
    .rd_active       (rd_active),
    .rd_lane         (rd_lane),
    .rd_y            (rd_y),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [2:0] exp_q[$];
  logic [2:0] obs;

  bit         m_active [NS];
  logic [2:0] m_lane   [NS];
  int         m_y      [NS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_active[i] = 1'b0;
      m_lane[i]   = 3'd0;
      m_y[i]      = 0;
    end
    exp_q.delete();
  endtask

  // Advance one clock; any pulse seen must match the head of the queue.
  task automatic cycle();
    logic [2:0] e;
    @(posedge clock);
    #1;
    obs = {hit_pulse, bad_strum_pulse, miss_pulse};
    if (obs != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {29'd0, obs}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pulse", {29'd0, obs}, {29'd0, e});
      end
    end
  endtask

  task automatic check_slots(input string tag, input bit full);
    for (int i = 0; i < NS; i++) begin
      rd_slot = 3'(i);
      #1;
      check_eq($sformatf("%s_active%0d", tag, i), {31'd0, rd_active}, {31'd0, m_active[i]});
      if (m_active[i] || full) begin
        check_eq($sformatf("%s_lane%0d", tag, i), {29'd0, rd_lane}, {29'd0, m_lane[i]});
        check_eq($sformatf("%s_y%0d", tag, i), {22'd0, rd_y}, m_y[i]);
      end
    end
  endtask

  task automatic read_slot(input int idx);
    rd_slot = 3'(idx);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset       = 1'b1;
    frame_tick  = 1'b0;
    spawn_valid = 1'b0;
    strum_valid = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_spawn(input int lane);
    int fi;
    fi = -1;
    for (int i = 0; i < NS; i++) if (!m_active[i] && fi < 0) fi = i;
    spawn_valid = 1'b1;
    spawn_lane  = 3'(lane);
    #1;
    check_eq("spawn_ready", {31'd0, spawn_ready}, (fi >= 0) ? 32'd1 : 32'd0);
    cycle();
    spawn_valid = 1'b0;
    if (fi >= 0 && lane < NL) begin
      m_active[fi] = 1'b1;
      m_lane[fi]   = 3'(lane);
      m_y[fi]      = 0;
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < NS; i++) begin
      if (m_active[i]) begin
        if (m_y[i] + SPD >= SH) begin
          m_active[i] = 1'b0;
          exp_q.push_back(P_MISS);
        end else begin
          m_y[i] = m_y[i] + SPD;
        end
      end
    end
  endtask

  task automatic do_frame(input bit check_busy);
    int n;
    model_advance();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      cycle();
    end
    if (check_busy) check_eq("busy_cycles", n, NS);
    check_eq("frame_pulses_left", exp_q.size(), 0);
  endtask

  task automatic do_strum(input int lane);
    int  best;
    int  lat;
    bit  found;
    best = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_active[i] && m_lane[i] == 3'(lane) && m_y[i] >= HMIN && m_y[i] <= HMAX &&
          (best < 0 || m_y[i] > m_y[best])) best = i;
    end
    exp_q.push_back((best >= 0) ? P_HIT : P_BAD);
    strum_valid = 1'b1;
    strum_lane  = 3'(lane);
    #1;
    check_eq("strum_ready", {31'd0, strum_ready}, 32'd1);
    cycle();
    strum_valid = 1'b0;
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 40) begin
      cycle();
      lat++;
      if (obs != 3'b000) found = 1'b1;
    end
    check_eq("strum_latency", lat, NS + 1);
    check_eq("strum_pulses_left", exp_q.size(), 0);
    if (best >= 0) begin
      m_active[best] = 1'b0;
      m_lane[best]   = 3'd0;
      m_y[best]      = 0;
    end
    cycle();
    check_slots("after_strum", 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rd_slot    = 3'd0;
    spawn_lane = 3'd0;
    strum_lane = 3'd0;
    do_reset();

    // Reset state
    #1;
    check_eq("rst_spawn_ready", {31'd0, spawn_ready}, 32'd1);
    check_eq("rst_strum_ready", {31'd0, strum_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_pulses", {29'd0, hit_pulse, bad_strum_pulse, miss_pulse}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_slots("rst", 1'b1);

    // First spawn lands in slot 0 and is readable next cycle
    do_spawn(2);
    read_slot(0);
    check_eq("spawn1_active", {31'd0, rd_active}, 32'd1);
    check_eq("spawn1_lane", {29'd0, rd_lane}, 32'd2);
    check_eq("spawn1_y", {22'd0, rd_y}, 32'd0);
    check_eq("spawn1_ready", {31'd0, spawn_ready}, 32'd1);

    // Out-of-range lane is accepted but writes nothing
    do_spawn(7);
    check_slots("ignored_lane", 1'b1);

    // Fill the pool
    for (int k = 0; k < NS - 1; k++) do_spawn($urandom_range(0, NL - 1));
    #1;
    check_eq("full_spawn_ready", {31'd0, spawn_ready}, 32'd0);
    do_spawn(1);
    do_frame(1'b1);
    check_slots("frame1", 1'b0);
    for (int i = 0; i < NS; i++) begin
      read_slot(i);
      check_eq($sformatf("frame1_y2_%0d", i), {22'd0, rd_y}, 32'd2);
    end

    // Retire off screen: slot 0 at 478 misses, slot 1 476 -> 478
    do_reset();
    do_spawn(3);
    do_frame(1'b1);
    do_spawn(0);
    repeat (238) do_frame(1'b0);
    check_slots("pre_miss", 1'b0);
    do_frame(1'b1);
    check_slots("post_miss", 1'b0);
    read_slot(0);
    check_eq("miss_slot0_cleared", {31'd0, rd_active}, 32'd0);
    read_slot(1);
    check_eq("miss_slot1_y", {22'd0, rd_y}, 32'd478);

    // Build lane-1 notes at slot 3 (y=410) and slot 5 (y=430)
    do_reset();
    do_spawn(0); do_spawn(0); do_spawn(0); do_spawn(2); do_spawn(0);
    repeat (190) do_frame(1'b0);
    do_spawn(1);
    repeat (10) do_frame(1'b0);
    do_strum(2);
    do_spawn(1);
    repeat (205) do_frame(1'b0);
    read_slot(3);
    check_eq("pre_hit_slot3_y", {22'd0, rd_y}, 32'd410);
    read_slot(5);
    check_eq("pre_hit_slot5_y", {22'd0, rd_y}, 32'd430);
    do_strum(1);
    read_slot(5);
    check_eq("hit_slot5_cleared", {31'd0, rd_active}, 32'd0);
    read_slot(3);
    check_eq("hit_slot3_active", {31'd0, rd_active}, 32'd1);
    check_eq("hit_slot3_y", {22'd0, rd_y}, 32'd410);

    // Just below the window -> bad strum; at the lower edge -> hit
    do_reset();
    do_spawn(4);
    repeat (199) do_frame(1'b0);
    do_strum(4);
    read_slot(0);
    check_eq("bad_slot0_active", {31'd0, rd_active}, 32'd1);
    check_eq("bad_slot0_y", {22'd0, rd_y}, 32'd398);
    do_frame(1'b0);
    do_strum(4);

    // Strum and frame_tick together: frame wins, strum is not taken
    do_spawn(3);
    model_advance();
    frame_tick  = 1'b1;
    strum_valid = 1'b1;
    strum_lane  = 3'd3;
    #1;
    check_eq("tie_strum_ready", {31'd0, strum_ready}, 32'd0);
    cycle();
    frame_tick  = 1'b0;
    strum_valid = 1'b0;
    check_eq("tie_busy", {31'd0, busy}, 32'd1);
    check_eq("tie_state", {30'd0, dbg_state}, {30'd0, ST_ADVANCE});
    repeat (NS + 12) cycle();
    check_eq("tie_pulses_left", exp_q.size(), 0);
    check_slots("tie", 1'b0);

    // Reset during JUDGE: no pulse, pool empty
    do_spawn(0);
    strum_valid = 1'b1;
    strum_lane  = 3'd0;
    cycle();
    strum_valid = 1'b0;
    repeat (4) cycle();
    check_eq("judge_state", {30'd0, dbg_state}, {30'd0, ST_JUDGE});
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_reset();
    check_eq("judge_rst_busy", {31'd0, busy}, 32'd0);
    check_slots("judge_rst", 1'b1);
    repeat (NS + 6) cycle();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests_run %0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
